// File: rtl/mem_bridge8_pkg.sv
// Shared definitions for the byte-serialising core memory bridge:
// FSM state encoding, write-size codes and the size-to-byte-count mapping.
package mem_bridge8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Number of RAM bytes touched by a store of the given size; the
    // reserved code touches none.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_bridge8_ram.sv
// Byte-wide synchronous single-port RAM, read-before-write.
// Read data for the address presented at an edge appears after that edge.
module mem_bridge8_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              we,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    // Registered read and optional write of the addressed byte.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_bridge8.sv
// Memory responder for the core bus: serialises each load/store into byte
// cycles on a synchronous byte RAM and releases the core with a one-cycle
// ce pulse when the access completes. All RAM-side outputs are registered.
module mem_bridge8
    import mem_bridge8_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       a,
    input  logic [31:0]       o,
    input  logic              w,
    input  logic [1:0]        ws,
    output logic [31:0]       i,
    output logic              ce,
    output logic [ADDR_W-1:0] ma,
    output logic [7:0]        md_out,
    output logic              mwe,
    input  logic [7:0]        md_in
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n, nxt;
    logic [ADDR_W-1:0] ma_n;
    logic [7:0]        md_out_n;
    logic              mwe_n, ce_n;
    logic [31:0]       i_n;
    logic [23:0]       lanes, lanes_n;
    logic [31:0]       o_q, o_n;
    logic [1:0]        ws_q, ws_n;

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ma_n     = ma;
        md_out_n = md_out;
        mwe_n    = mwe;
        ce_n     = 1'b0;
        i_n      = i;
        lanes_n  = lanes;
        o_n      = o_q;
        ws_n     = ws_q;
        nxt      = cnt + 3'd1;

        case (state)
            ST_IDLE: begin
                cnt_n = 3'd0;
                ma_n  = ADDR_W'(a);
                o_n   = o;
                ws_n  = ws;
                if (w) begin
                    // A reserved size takes one dummy WR beat with the write
                    // enable held low, so it releases the core on the same
                    // cycle as a byte store without touching the RAM.
                    state_n = ST_WR;
                    if (ws != SZ_RSVD) begin
                        mwe_n    = 1'b1;
                        md_out_n = o[7:0];
                    end else begin
                        mwe_n = 1'b0;
                    end
                end else begin
                    state_n = ST_RD;
                    mwe_n   = 1'b0;
                end
            end
            ST_WR: begin
                cnt_n = nxt;
                if (nxt < size_bytes(ws_q)) begin
                    ma_n     = ma + ADDR_ONE;
                    md_out_n = o_q[{nxt[1:0], 3'b000} +: 8];
                end else begin
                    mwe_n   = 1'b0;
                    ce_n    = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_RD: begin
                // Address runs two edges ahead of the returning RAM byte.
                cnt_n = nxt;
                if (cnt < 3'd3) begin
                    ma_n = ma + ADDR_ONE;
                end
                case (cnt)
                    3'd1: lanes_n[7:0]   = md_in;
                    3'd2: lanes_n[15:8]  = md_in;
                    3'd3: lanes_n[23:16] = md_in;
                    3'd4: begin
                        i_n     = {md_in, lanes};
                        ce_n    = 1'b1;
                        state_n = ST_DONE;
                    end
                    default: ;
                endcase
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Control and core/RAM-facing registers, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= 3'd0;
            ma     <= '0;
            md_out <= 8'd0;
            mwe    <= 1'b0;
            ce     <= 1'b0;
            i      <= 32'd0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ma     <= ma_n;
            md_out <= md_out_n;
            mwe    <= mwe_n;
            ce     <= ce_n;
            i      <= i_n;
        end
    end

    // Latched request and partial read word; only meaningful mid-access.
    always_ff @(posedge clock) begin
        o_q   <= o_n;
        ws_q  <= ws_n;
        lanes <= lanes_n;
    end

endmodule

// File: tb/tb_mem_bridge8.sv
// Directed bench for mem_bridge8 with a byte RAM attached: every access
// pushes its expected latency, load word and write-enable cycle count to a
// scoreboard that is popped when the ce pulse arrives.
module tb_mem_bridge8;
    import mem_bridge8_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       a     = 32'd0;
    logic [31:0]       o     = 32'd0;
    logic              w     = 1'b0;
    logic [1:0]        ws    = 2'b00;
    logic [31:0]       i;
    logic              ce;
    logic [ADDR_W-1:0] ma;
    logic [7:0]        md_out;
    logic              mwe;
    logic [7:0]        md_in;

    mem_bridge8 #(.ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .a(a), .o(o), .w(w), .ws(ws),
        .i(i), .ce(ce), .ma(ma), .md_out(md_out), .mwe(mwe), .md_in(md_in)
    );

    mem_bridge8_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clock(clock), .addr(ma), .wdata(md_out), .we(mwe), .rdata(md_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          lat;
        logic [31:0] data;
        int          mwe_cycles;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem_model [DEPTH];
    logic [31:0] i_model = 32'd0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_ram(input int addr);
        chk($sformatf("ram[%03h]", addr), {24'd0, u_ram.mem[addr]}, {24'd0, mem_model[addr]});
    endtask

    function automatic int wrap(input logic [31:0] addr, input int k);
        return int'((addr + 32'(k)) & 32'(DEPTH - 1));
    endfunction

    // Called just after a falling edge with the bridge idle; returns just
    // after a falling edge with the bridge idle again.
    task automatic access(input logic [31:0] addr, input logic [31:0] data,
                          input logic wr, input logic [1:0] sz);
        exp_t e, got_e;
        int   n, cyc, mw;
        n = int'(size_bytes(sz));
        if (!wr) begin
            for (int k = 0; k < 4; k++) i_model[8*k +: 8] = mem_model[wrap(addr, k)];
            e.lat        = 5;
            e.mwe_cycles = 0;
        end else begin
            for (int k = 0; k < n; k++) mem_model[wrap(addr, k)] = data[8*k +: 8];
            e.lat        = (n == 0) ? 1 : n;
            e.mwe_cycles = n;
        end
        e.data = i_model;
        sb.push_back(e);

        a = addr; o = data; w = wr; ws = sz;
        @(posedge clock); #1;
        // The bridge must work from its latched copy from here on.
        a = $urandom; o = $urandom; w = 1'($urandom); ws = 2'($urandom);
        cyc = 0; mw = 0;
        while (!ce && cyc < 20) begin
            if (mwe) mw++;
            @(posedge clock); #1;
            cyc++;
        end
        chk("ce_seen", {31'd0, ce}, 32'd1);
        chk("mwe_at_ce", {31'd0, mwe}, 32'd0);
        got_e = sb.pop_front();
        chk("latency", 32'(cyc), 32'(got_e.lat));
        chk("i", i, got_e.data);
        chk("mwe_cycles", 32'(mw), 32'(got_e.mwe_cycles));
        @(posedge clock); #1;
        chk("ce_drop", {31'd0, ce}, 32'd0);
        @(negedge clock);
    endtask

    initial begin
        // Reset state
        @(posedge clock); @(posedge clock); #1;
        chk("rst_ce", {31'd0, ce}, 32'd0);
        chk("rst_i", i, 32'd0);
        chk("rst_ma", {22'd0, ma}, 32'd0);
        chk("rst_md_out", {24'd0, md_out}, 32'd0);
        chk("rst_mwe", {31'd0, mwe}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Preload through the bus (the 0x3FE word also exercises write wrap)
        access(32'h10,  32'h44332211, 1'b1, SZ_WORD);
        access(32'h20,  32'h5A5A5A5A, 1'b1, SZ_WORD);
        access(32'h3FE, 32'hD4C3B2A1, 1'b1, SZ_WORD);
        access(32'h50,  32'hEEEEEEEE, 1'b1, SZ_WORD);
        access(32'h60,  32'h0BADF00D, 1'b1, SZ_WORD);

        // Word read
        access(32'h10, 32'h0, 1'b0, SZ_BYTE);

        // Byte write leaves neighbours and i alone
        access(32'h21, 32'hAABBCCDD, 1'b1, SZ_BYTE);
        for (int k = 'h20; k <= 'h22; k++) chk_ram(k);

        // Half and word writes, then read back
        access(32'h30, 32'h12345678, 1'b1, SZ_HALF);
        access(32'h40, 32'h12345678, 1'b1, SZ_WORD);
        chk_ram('h30); chk_ram('h31);
        for (int k = 'h40; k <= 'h43; k++) chk_ram(k);
        access(32'h40, 32'h0, 1'b0, SZ_BYTE);

        // Upper address bits ignored, read wraps from 0x3FF to 0x000
        access(32'hFFFF_03FE, 32'h0, 1'b0, SZ_BYTE);

        // Reserved size: no RAM traffic, i unchanged
        access(32'h60, 32'hFFFFFFFF, 1'b1, SZ_RSVD);
        for (int k = 'h60; k <= 'h63; k++) chk_ram(k);

        // Reset in the third cycle of a word write
        a = 32'h50; o = 32'h12345678; w = 1'b1; ws = SZ_WORD;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_ce", {31'd0, ce}, 32'd0);
        chk("abort_i", i, 32'd0);
        chk("abort_ma", {22'd0, ma}, 32'd0);
        chk("abort_md_out", {24'd0, md_out}, 32'd0);
        chk("abort_mwe", {31'd0, mwe}, 32'd0);
        i_model = 32'd0;
        mem_model['h50] = 8'h78;
        mem_model['h51] = 8'h56;
        @(posedge clock); #1;
        chk("abort_mwe_hold", {31'd0, mwe}, 32'd0);
        for (int k = 'h50; k <= 'h53; k++) chk_ram(k);
        @(negedge clock);
        reset = 1'b0;
        access(32'h50, 32'h0, 1'b0, SZ_BYTE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
